// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding, default bus address and R/W levels.
// Used by the target receiver and by the bus synchroniser consumers.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ACK_ADDR = 3'd2,
        ST_DATA     = 3'd3,
        ST_ACK_DATA = 3'd4,
        ST_IGNORE   = 3'd5
    } state_t;

    localparam logic [6:0] DEFAULT_ADDR = 7'h50;
    localparam logic       RW_WRITE     = 1'b0;
    localparam logic       RW_READ      = 1'b1;

    // First byte of a transfer as it appears on the wire.
    function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
        return {addr, rw};
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with one history flop per line; derives SCL edges and
// START/STOP conditions from the synchronised signals only.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_evt,
    output logic stop_evt,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_d;
    logic                   sda_d;

    // Synchronisers preset to 1 so a reset looks like an idle bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;

    // SCL must be high in both sampled cycles, so a simultaneous SCL edge wins.
    assign start_evt = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_evt  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: matches a 7-bit address, ACKs address and data bytes,
// and presents each received byte with a one-clock rx_valid strobe.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = DEFAULT_ADDR,
    parameter logic       WRITE_BIT   = RW_WRITE,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda,
    output logic       i2c_sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy,
    output logic [7:0] byte_cnt
);

    logic       scl_rise;
    logic       scl_fall;
    logic       start_evt;
    logic       stop_evt;
    logic       sda_s;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] byte_in;

    logic       shift_en;
    logic       byte_done;
    logic       addr_ok;
    logic       in_ack;
    logic       ack_on;
    logic       ack_off;
    logic       bus_start;
    logic       bus_stop;
    logic       load_data;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl      (i2c_scl),
        .sda      (i2c_sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_evt(start_evt),
        .stop_evt (stop_evt),
        .sda_s    (sda_s)
    );

    assign byte_in = {shreg, sda_s};
    assign addr_ok = (byte_in == addr_byte(SLAVE_ADDR, WRITE_BIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (stop_evt && state != ST_IDLE) begin
            state_nxt = ST_IDLE;
        end else if (start_evt) begin
            state_nxt = ST_ADDR;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise && bit_cnt == 3'd7) begin
                        state_nxt = addr_ok ? ST_ACK_ADDR : ST_IGNORE;
                    end
                end
                ST_ACK_ADDR: begin
                    if (scl_fall && i2c_sda_oe) state_nxt = ST_DATA;
                end
                ST_DATA: begin
                    if (scl_rise && bit_cnt == 3'd7) state_nxt = ST_ACK_DATA;
                end
                ST_ACK_DATA: begin
                    if (scl_fall && i2c_sda_oe) state_nxt = ST_DATA;
                end
                default: begin
                end
            endcase
        end
    end

    // The first SCL fall in an ACK state starts the drive, the second ends it.
    always_comb begin
        bus_start = start_evt;
        bus_stop  = stop_evt && (state != ST_IDLE);
        shift_en  = scl_rise && (state == ST_ADDR || state == ST_DATA);
        byte_done = shift_en && (bit_cnt == 3'd7);
        load_data = byte_done && (state == ST_DATA);
        in_ack    = (state == ST_ACK_ADDR) || (state == ST_ACK_DATA);
        ack_on    = scl_fall && in_ack && !i2c_sda_oe;
        ack_off   = scl_fall && in_ack && i2c_sda_oe;
    end

    always_ff @(posedge clk) begin
        if (shift_en) shreg <= byte_in[6:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i2c_sda_oe <= 1'b0;
            addr_match <= 1'b0;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
            byte_cnt   <= 8'd0;
            bit_cnt    <= 3'd0;
        end else begin
            start_det <= bus_start;
            stop_det  <= bus_stop;
            rx_valid  <= load_data;
            if (bus_start || bus_stop) begin
                i2c_sda_oe <= 1'b0;
                addr_match <= 1'b0;
                bit_cnt    <= 3'd0;
                if (bus_start) byte_cnt <= 8'd0;
            end else begin
                if (ack_on) begin
                    i2c_sda_oe <= 1'b1;
                    if (state == ST_ACK_ADDR) addr_match <= 1'b1;
                end else if (ack_off) begin
                    i2c_sda_oe <= 1'b0;
                    bit_cnt    <= 3'd0;
                end
                if (shift_en) bit_cnt <= bit_cnt + 3'd1;
                if (load_data) begin
                    rx_data  <= byte_in;
                    byte_cnt <= byte_cnt + 8'd1;
                end
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: a bit-banged master on a wired-AND SDA line,
// a vector table of single-byte writes, and hand sequences for the corner cases.
module tb_i2c_slave_rx;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_sda;
    logic       sda_bus;
    logic       i2c_sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       start_det;
    logic       stop_det;
    logic       busy;
    logic [7:0] byte_cnt;

    assign sda_bus = m_sda & ~i2c_sda_oe;

    i2c_slave_rx #(
        .SLAVE_ADDR (7'h50),
        .WRITE_BIT  (1'b0),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i2c_scl   (scl),
        .i2c_sda   (sda_bus),
        .i2c_sda_oe(i2c_sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .addr_match(addr_match),
        .start_det (start_det),
        .stop_det  (stop_det),
        .busy      (busy),
        .byte_cnt  (byte_cnt)
    );

    always #5 clk = ~clk;

    int         rx_cnt = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    logic [7:0] rx_log [0:63];

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt % 64] = rx_data;
            rx_cnt++;
        end
        if (start_det) start_cnt++;
        if (stop_det) stop_cnt++;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_q(input int n);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b0; wait_q(1);
        scl = 1'b0;   wait_q(1);
    endtask

    task automatic bus_rstart();
        m_sda = 1'b1; wait_q(1);
        scl = 1'b1;   wait_q(1);
        m_sda = 1'b0; wait_q(1);
        scl = 1'b0;   wait_q(1);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_q(1);
        scl = 1'b1;   wait_q(1);
        m_sda = 1'b1; wait_q(1);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;  wait_q(1);
        scl = 1'b1; wait_q(2);
        scl = 1'b0; wait_q(1);
    endtask

    // ack = SDA seen low in the middle of the 9th clock high phase
    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; wait_q(1);
        scl = 1'b1;   wait_q(1);
        ack = (sda_bus === 1'b0) && (i2c_sda_oe === 1'b1);
        wait_q(1);
        scl = 1'b0;   wait_q(1);
    endtask

    task automatic write_txn(input logic [6:0] a, input logic rw, input logic [7:0] d,
                             output logic ack_a, output logic ack_d,
                             output logic am_mid, output logic busy_mid);
        bus_start();
        send_byte({a, rw}, ack_a);
        am_mid   = addr_match;
        busy_mid = busy;
        send_byte(d, ack_d);
        bus_stop();
        wait_q(1);
    endtask

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
        logic       ack_a;
        logic       ack_d;
        int         n_valid;
        logic [7:0] rx;
        logic [7:0] bcnt;
    } vec_t;

    vec_t vecs [0:4];

    initial begin
        logic ack_a, ack_d, am_mid, busy_mid, ack_tmp;
        int   rx0, st0, sp0;

        vecs[0] = '{7'h50, 1'b0, 8'hAA, 1'b1, 1'b1, 1, 8'hAA, 8'd1};
        vecs[1] = '{7'h51, 1'b0, 8'h55, 1'b0, 1'b0, 0, 8'hAA, 8'd0};
        vecs[2] = '{7'h50, 1'b1, 8'h55, 1'b0, 1'b0, 0, 8'hAA, 8'd0};
        vecs[3] = '{7'h50, 1'b0, 8'h00, 1'b1, 1'b1, 1, 8'h00, 8'd1};
        vecs[4] = '{7'h50, 1'b0, 8'hFF, 1'b1, 1'b1, 1, 8'hFF, 8'd1};

        reset = 1'b1;
        scl   = 1'b1;
        m_sda = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_outputs",
              {i2c_sda_oe, rx_data, rx_valid, addr_match, start_det, stop_det, busy, byte_cnt},
              '0);
        reset = 1'b0;
        wait_q(2);

        for (int v = 0; v < 5; v++) begin
            rx0 = rx_cnt; st0 = start_cnt; sp0 = stop_cnt;
            write_txn(vecs[v].addr, vecs[v].rw, vecs[v].data, ack_a, ack_d, am_mid, busy_mid);
            check($sformatf("v%0d_ack_addr", v), ack_a, vecs[v].ack_a);
            check($sformatf("v%0d_ack_data", v), ack_d, vecs[v].ack_d);
            check($sformatf("v%0d_addr_match_mid", v), am_mid, vecs[v].ack_a);
            check($sformatf("v%0d_busy_mid", v), busy_mid, 1'b1);
            check($sformatf("v%0d_rx_valid_cnt", v), rx_cnt - rx0, vecs[v].n_valid);
            check($sformatf("v%0d_rx_data", v), rx_data, vecs[v].rx);
            check($sformatf("v%0d_byte_cnt", v), byte_cnt, vecs[v].bcnt);
            check($sformatf("v%0d_start_cnt", v), start_cnt - st0, 1);
            check($sformatf("v%0d_stop_cnt", v), stop_cnt - sp0, 1);
            check($sformatf("v%0d_idle_after", v), {busy, addr_match, i2c_sda_oe}, 3'b000);
        end

        // Multi-byte write, repeated START, second write.
        rx0 = rx_cnt; st0 = start_cnt;
        bus_start();
        send_byte(8'hA0, ack_tmp);
        send_byte(8'h01, ack_tmp);
        send_byte(8'h02, ack_tmp);
        check("rs_byte_cnt_before", byte_cnt, 8'd2);
        check("rs_addr_match_before", addr_match, 1'b1);
        bus_rstart();
        check("rs_addr_match_cleared", addr_match, 1'b0);
        check("rs_byte_cnt_cleared", byte_cnt, 8'd0);
        send_byte(8'hA0, ack_tmp);
        check("rs_ack_addr2", ack_tmp, 1'b1);
        send_byte(8'h03, ack_tmp);
        bus_stop();
        wait_q(1);
        check("rs_valid_cnt", rx_cnt - rx0, 3);
        check("rs_byte0", rx_log[rx0 % 64], 8'h01);
        check("rs_byte1", rx_log[(rx0 + 1) % 64], 8'h02);
        check("rs_byte2", rx_log[(rx0 + 2) % 64], 8'h03);
        check("rs_start_cnt", start_cnt - st0, 2);
        check("rs_byte_cnt_end", byte_cnt, 8'd1);

        // STOP after four data bits of 0xF0, then a clean write of 0x3C.
        rx0 = rx_cnt;
        bus_start();
        send_byte(8'hA0, ack_tmp);
        for (int i = 7; i >= 4; i--) send_bit(1'b1);
        bus_stop();
        wait_q(1);
        check("mid_stop_no_valid", rx_cnt - rx0, 0);
        check("mid_stop_idle", busy, 1'b0);
        write_txn(7'h50, 1'b0, 8'h3C, ack_a, ack_d, am_mid, busy_mid);
        check("mid_stop_next_valid", rx_cnt - rx0, 1);
        check("mid_stop_next_data", rx_data, 8'h3C);
        check("mid_stop_next_ack", ack_d, 1'b1);

        // Reset while the data ACK is being driven.
        bus_start();
        send_byte(8'hA0, ack_tmp);
        for (int i = 7; i >= 0; i--) send_bit(1'b0);
        check("ack_data_driving", i2c_sda_oe, 1'b1);
        reset = 1'b1;
        #1;
        check("reset_async_oe", i2c_sda_oe, 1'b0);
        check("reset_async_outputs",
              {rx_data, rx_valid, addr_match, start_det, stop_det, busy, byte_cnt}, '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        scl   = 1'b1;
        m_sda = 1'b1;
        wait_q(2);
        rx0 = rx_cnt;
        write_txn(7'h50, 1'b0, 8'h7E, ack_a, ack_d, am_mid, busy_mid);
        check("post_reset_ack_addr", ack_a, 1'b1);
        check("post_reset_valid", rx_cnt - rx0, 1);
        check("post_reset_data", rx_data, 8'h7E);
        check("post_reset_byte_cnt", byte_cnt, 8'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
